// File: rtl/rchdc_pkg.sv
// Shared types and default widths for the classification result path.
package rchdc_pkg;

  localparam int unsigned CLS_SEL_DW      = 32;
  localparam int unsigned CLS_SEL_CLSW    = 16;
  localparam int unsigned CLS_SEL_NUM_CLS = 10;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } cls_sel_state_t;

endpackage

// File: rtl/Compare.sv
// Min-select comparator: passes the challenger (b) only when strictly lower than
// the incumbent (a), so ties keep the incumbent.
module Compare
  import rchdc_pkg::*;
#(
  parameter int unsigned DW   = CLS_SEL_DW,
  parameter int unsigned CLSW = CLS_SEL_CLSW
) (
  input  logic [DW-1:0]   i_a_score,
  input  logic [CLSW-1:0] i_a_cls,
  input  logic [DW-1:0]   i_b_score,
  input  logic [CLSW-1:0] i_b_cls,
  output logic [DW-1:0]   o_min_score,
  output logic [CLSW-1:0] o_min_cls
);

  logic w_b_lt;

  assign w_b_lt      = (i_b_score < i_a_score);
  assign o_min_score = w_b_lt ? i_b_score : i_a_score;
  assign o_min_cls   = w_b_lt ? i_b_cls   : i_a_cls;

endmodule

// File: rtl/class_select_ctrl.sv
// Reduces a frame of per-class distance scores to the nearest class, one beat per cycle.
// Optional runner-up margin tracking is enabled with `define CLASS_SELECT_MARGIN_EN.
module class_select_ctrl
  import rchdc_pkg::*;
#(
  parameter int unsigned DW      = CLS_SEL_DW,
  parameter int unsigned CLSW    = CLS_SEL_CLSW,
  parameter int unsigned NUM_CLS = CLS_SEL_NUM_CLS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_score,
  input  logic [CLSW-1:0] s_cls,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [CLSW-1:0] m_cls,
  output logic [DW-1:0]   m_score,
  output logic [DW-1:0]   m_margin,
  output logic [CLSW-1:0] m_count,
  output logic            m_err
);

  localparam logic [CLSW-1:0] LP_NUM = CLSW'(NUM_CLS);

  cls_sel_state_t r_state;
  cls_sel_state_t w_state_nxt;

  logic [DW-1:0]   r_best_score;
  logic [CLSW-1:0] r_best_cls;
  logic [CLSW-1:0] r_cnt;

  logic [CLSW-1:0] r_m_cls;
  logic [DW-1:0]   r_m_score;
  logic [CLSW-1:0] r_m_count;
  logic            r_m_err;

  logic            w_accept;
  logic            w_first;
  logic            w_frame_end;
  logic            w_err_nxt;
  logic [CLSW-1:0] w_cnt_nxt;
  logic [DW-1:0]   w_min_score;
  logic [CLSW-1:0] w_min_cls;
  logic [DW-1:0]   w_best_score_nxt;
  logic [CLSW-1:0] w_best_cls_nxt;

  Compare #(
    .DW   (DW),
    .CLSW (CLSW)
  ) u_compare (
    .i_a_score   (r_best_score),
    .i_a_cls     (r_best_cls),
    .i_b_score   (s_score),
    .i_b_cls     (s_cls),
    .o_min_score (w_min_score),
    .o_min_cls   (w_min_cls)
  );

  // s_ready depends only on state and reset, never on s_valid
  assign s_ready  = !rst && (r_state != DONE);
  assign m_valid  = (r_state == DONE);
  assign w_accept = s_valid && s_ready;
  assign w_first  = (r_state == IDLE);

  always_comb begin
    w_cnt_nxt        = w_first ? CLSW'(1) : r_cnt + CLSW'(1);
    w_best_score_nxt = w_first ? s_score : w_min_score;
    w_best_cls_nxt   = w_first ? s_cls   : w_min_cls;
    w_frame_end      = w_accept && (s_last || (w_cnt_nxt == LP_NUM));
    w_err_nxt        = !(s_last && (w_cnt_nxt == LP_NUM));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, ACCUM: begin
        if (w_frame_end) begin
          w_state_nxt = DONE;
        end else if (w_accept) begin
          w_state_nxt = ACCUM;
        end
      end
      DONE: begin
        if (m_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_best_score <= '0;
      r_best_cls   <= '0;
      r_cnt        <= '0;
      r_m_cls      <= '0;
      r_m_score    <= '0;
      r_m_count    <= '0;
      r_m_err      <= 1'b0;
    end else if (w_accept) begin
      r_best_score <= w_best_score_nxt;
      r_best_cls   <= w_best_cls_nxt;
      r_cnt        <= w_cnt_nxt;
      if (w_frame_end) begin
        r_m_cls   <= w_best_cls_nxt;
        r_m_score <= w_best_score_nxt;
        r_m_count <= w_cnt_nxt;
        r_m_err   <= w_err_nxt;
      end
    end
  end

  assign m_cls   = r_m_cls;
  assign m_score = r_m_score;
  assign m_count = r_m_count;
  assign m_err   = r_m_err;

`ifdef CLASS_SELECT_MARGIN_EN
  logic [DW-1:0] r_second;
  logic [DW-1:0] r_m_margin;
  logic          w_new_lt;
  logic [DW-1:0] w_second_nxt;
  logic [DW-1:0] w_margin_nxt;

  // The comparator output differs from the incumbent only when the new score strictly wins
  assign w_new_lt = (w_min_score != r_best_score);

  always_comb begin
    w_second_nxt = r_second;
    if (w_first) begin
      w_second_nxt = '1;
    end else if (w_new_lt) begin
      w_second_nxt = r_best_score;
    end else if (s_score < r_second) begin
      w_second_nxt = s_score;
    end
    w_margin_nxt = w_first ? '1 : (w_second_nxt - w_best_score_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_second   <= '0;
      r_m_margin <= '0;
    end else if (w_accept) begin
      r_second <= w_second_nxt;
      if (w_frame_end) begin
        r_m_margin <= w_margin_nxt;
      end
    end
  end

  assign m_margin = r_m_margin;
`else
  assign m_margin = '0;
`endif

endmodule

// File: tb/tb_class_select_ctrl.sv
// Randomized and directed bench for class_select_ctrl against a frame-level reference model.
module tb_class_select_ctrl;

  localparam int unsigned DW   = 32;
  localparam int unsigned CLSW = 16;
  localparam int unsigned NUM  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [DW-1:0]   s_score = '0;
  logic [CLSW-1:0] s_cls = '0;
  logic            s_last = 1'b0;
  logic            m_valid;
  logic            m_ready = 1'b1;
  logic [CLSW-1:0] m_cls;
  logic [DW-1:0]   m_score;
  logic [DW-1:0]   m_margin;
  logic [CLSW-1:0] m_count;
  logic            m_err;

  always #5 clk = ~clk;

  class_select_ctrl #(
    .DW      (DW),
    .CLSW    (CLSW),
    .NUM_CLS (NUM)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_score  (s_score),
    .s_cls    (s_cls),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_cls    (m_cls),
    .m_score  (m_score),
    .m_margin (m_margin),
    .m_count  (m_count),
    .m_err    (m_err)
  );

  typedef struct {
    logic [CLSW-1:0] cls;
    logic [DW-1:0]   score;
    logic [DW-1:0]   margin;
    logic [CLSW-1:0] cnt;
    logic            err;
  } res_t;

  res_t            exp_q[$];
  logic [DW-1:0]   fr_sc[$];
  logic [CLSW-1:0] fr_cl[$];

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic        rst_prev = 1'b0;
  logic        rdy_rand = 1'b0;
  logic        rdy_fix  = 1'b1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, req);
  endtask

  // Frame-level reference: nearest (first lowest) class, runner-up from the remaining scores
  function automatic void finalize(input logic last);
    res_t r;
    int bi;
    logic [DW-1:0] sec;
    bi = 0;
    for (int i = 1; i < fr_sc.size(); i++) if (fr_sc[i] < fr_sc[bi]) bi = i;
    sec = '1;
    for (int i = 0; i < fr_sc.size(); i++) if (i != bi && fr_sc[i] < sec) sec = fr_sc[i];
    r.cls   = fr_cl[bi];
    r.score = fr_sc[bi];
    r.cnt   = CLSW'(fr_sc.size());
    r.err   = !(last && fr_sc.size() == NUM);
`ifdef CLASS_SELECT_MARGIN_EN
    r.margin = (fr_sc.size() == 1) ? '1 : sec - fr_sc[bi];
`else
    r.margin = '0;
`endif
    exp_q.push_back(r);
    fr_sc.delete();
    fr_cl.delete();
  endfunction

  always @(posedge clk) begin
    #1;
    m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_s_ready", s_ready, 0);
      exp_q.delete();
      fr_sc.delete();
      fr_cl.delete();
    end else begin
      chk("m_valid", m_valid, 64'(exp_q.size() != 0));
      chk("s_ready", s_ready, 64'(exp_q.size() == 0));
      if (m_valid && exp_q.size() != 0) begin
        chk("m_cls",    m_cls,    exp_q[0].cls);
        chk("m_score",  m_score,  exp_q[0].score);
        chk("m_margin", m_margin, exp_q[0].margin);
        chk("m_count",  m_count,  exp_q[0].cnt);
        chk("m_err",    m_err,    exp_q[0].err);
        if (m_ready) void'(exp_q.pop_front());
      end
      if (s_valid && s_ready) begin
        fr_sc.push_back(s_score);
        fr_cl.push_back(s_cls);
        if (s_last || fr_sc.size() == NUM) finalize(s_last);
      end
    end
    if (rst_prev) begin
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_cls",   m_cls,   0);
      chk("rst_m_score", m_score, 0);
      chk("rst_m_count", m_count, 0);
      chk("rst_m_err",   m_err,   0);
      chk("rst_m_margin", m_margin, 0);
    end
    rst_prev = rst;
  end

  task automatic send_beat(input logic [DW-1:0] sc, input logic [CLSW-1:0] c, input logic l,
                           input int unsigned gap);
    int unsigned t;
    s_valid = 1'b0;
    if (gap != 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_score = sc;
    s_cls   = c;
    s_last  = l;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!s_ready && t < 100);
    if (!s_ready) chk("send_timeout", s_ready, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic [CLSW-1:0] c, input logic [DW-1:0] sc,
                            input logic [CLSW-1:0] n, input logic e, input logic [DW-1:0] mg);
    int unsigned t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!m_valid && t < 50);
    chk({tag, "_valid"}, m_valid, 1);
    chk({tag, "_cls"},   m_cls,   c);
    chk({tag, "_score"}, m_score, sc);
    chk({tag, "_count"}, m_count, n);
    chk({tag, "_err"},   m_err,   e);
`ifdef CLASS_SELECT_MARGIN_EN
    chk({tag, "_margin"}, m_margin, mg);
`else
    chk({tag, "_margin"}, m_margin, 0);
    if (mg == '1) t = 0;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int unsigned t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] t1_sc [4] = '{40, 12, 30, 12};
    logic [DW-1:0] t5_sc [4] = '{9, 3, 3, 8};
    logic [DW-1:0] t6_sc [4] = '{20, 5, 11, 5};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // T1: tie on 12 keeps the earlier class
    for (int i = 0; i < 4; i++) send_beat(t1_sc[i], CLSW'(i), i == 3, 0);
    expect_res("t1", 1, 12, 4, 0, 0);

    // T2: single-beat frame
    send_beat(7, 5, 1'b1, 0);
    expect_res("t2", 5, 7, 1, 1, '1);

    // T3: overflow after NUM beats, leftovers form the next frame
    for (int i = 0; i < 6; i++) send_beat(DW'(5 + i), CLSW'(i), 1'b0, 0);
    send_beat(2, 9, 1'b1, 0);
    drain();

    // T4: result held while consumer stalls
    rdy_fix = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(DW'(4 - i), CLSW'(10 + i), i == 3, 0);
    repeat (12) @(posedge clk);
    #1;
    rdy_fix = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(DW'(100 + i), CLSW'(i), i == 3, 0);
    drain();

    // T5: gaps inside the frame
    for (int i = 0; i < 4; i++) send_beat(t5_sc[i], CLSW'(i), i == 3, $urandom_range(1, 3));
    expect_res("t5", 1, 3, 4, 0, 0);

    // T6: reset mid-frame discards the partial frame
    send_beat(1, 1, 1'b0, 0);
    send_beat(2, 2, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(t6_sc[i], CLSW'(9 - i), i == 3, 0);
    expect_res("t6", 8, 5, 4, 0, 0);

    // Random frames, gaps, ties and consumer stalls
    rdy_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send_beat(($urandom_range(0, 7) == 0) ? DW'($urandom) : DW'($urandom_range(0, 15)),
                CLSW'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 2));
    end
    send_beat(DW'($urandom_range(0, 15)), CLSW'($urandom), 1'b1, 0);
    rdy_rand = 1'b0;
    rdy_fix  = 1'b1;
    drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
